// File: rtl/controlador_entrada_senha_pkg.sv
// Shared items for the password-entry controller: password packet, key codes and FSM states.
package controlador_entrada_senha_pkg;

    localparam int unsigned SENHA_DIGITOS = 20;

    localparam logic [3:0] TECLA_CONFIRMA = 4'hA;
    localparam logic [3:0] TECLA_NULA     = 4'hF;

    // digits[0] holds the most recently typed digit
    typedef struct packed {
        logic [SENHA_DIGITOS-1:0][3:0] digits;
    } senhaPac_t;

    typedef enum logic [1:0] {
        OCIOSO,
        COLETA,
        ENVIA
    } estado_t;

    function automatic logic eh_digito(input logic [3:0] tecla);
        return tecla <= 4'd9;
    endfunction

endpackage

// File: rtl/controlador_entrada_senha_registrador_senha.sv
// Password shift buffer with saturating digit counter; clear takes priority over shift.
module registrador_senha
    import controlador_entrada_senha_pkg::*;
#(
    parameter int unsigned MAX_DIGITOS = SENHA_DIGITOS,
    parameter int unsigned CW          = $clog2(MAX_DIGITOS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift_in,
    input  logic          clear,
    input  logic [3:0]    digit,
    output senhaPac_t     digits,
    output logic [CW-1:0] count
);

    senhaPac_t     digits_q, digits_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        digits_d = digits_q;
        count_d  = count_q;
        if (clear) begin
            // all-ones fill marks every slot as TECLA_NULA
            digits_d = '1;
            count_d  = '0;
        end else if (shift_in) begin
            digits_d.digits = {digits_q.digits[SENHA_DIGITOS-2:0], digit};
            if (count_q != CW'(MAX_DIGITOS)) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '1;
            count_q  <= '0;
        end else begin
            digits_q <= digits_d;
            count_q  <= count_d;
        end
    end

    assign digits = digits_q;
    assign count  = count_q;

endmodule

// File: rtl/controlador_entrada_senha.sv
// Keypad password-entry controller between the key decoder and the lock FSM.
// Optional inactivity timeout built only when SENHA_TIMEOUT_EN is defined.
module controlador_entrada_senha
    import controlador_entrada_senha_pkg::*;
#(
    parameter int unsigned MAX_DIGITOS    = SENHA_DIGITOS,
    parameter int unsigned MIN_DIGITOS    = 4,
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               habilitar,
    input  logic                               tecla_valid,
    input  logic [3:0]                         tecla_value,
    output logic                               dec_enable,
    output senhaPac_t                          senha_value,
    output logic                               senha_valid,
    output logic [$clog2(MAX_DIGITOS+1)-1:0]   num_digitos,
    output logic                               erro_curta,
    output logic                               timeout_pulse
);

    localparam int unsigned CW = $clog2(MAX_DIGITOS + 1);

    if (MAX_DIGITOS != SENHA_DIGITOS || MIN_DIGITOS == 0 || MIN_DIGITOS > MAX_DIGITOS ||
        TIMEOUT_CICLOS < 2) begin : g_param_invalido
        $error("controlador_entrada_senha: inconsistent parameters");
    end

    estado_t       estado_q, estado_d;
    logic          tecla_valid_q;
    logic          senha_valid_q, senha_valid_d;
    logic          erro_curta_q, erro_curta_d;
    senhaPac_t     senha_value_q, senha_value_d;
    logic          evento;
    logic          shift_in, clear;
    logic          timeout_hit;
    senhaPac_t     buffer;
    logic [CW-1:0] contagem;

    assign evento = tecla_valid & ~tecla_valid_q;

    registrador_senha #(
        .MAX_DIGITOS (MAX_DIGITOS),
        .CW          (CW)
    ) u_registrador (
        .clk      (clk),
        .rst      (rst),
        .shift_in (shift_in),
        .clear    (clear),
        .digit    (tecla_value),
        .digits   (buffer),
        .count    (contagem)
    );

    always_comb begin
        estado_d      = estado_q;
        shift_in      = 1'b0;
        clear         = 1'b0;
        senha_valid_d = 1'b0;
        erro_curta_d  = 1'b0;
        senha_value_d = senha_value_q;
        case (estado_q)
            OCIOSO: begin
                if (habilitar) estado_d = COLETA;
            end
            COLETA: begin
                // habilitar falling outranks a key edge; a key edge outranks the timeout
                if (!habilitar) begin
                    estado_d = OCIOSO;
                    clear    = 1'b1;
                end else if (evento) begin
                    if (eh_digito(tecla_value)) begin
                        shift_in = 1'b1;
                    end else if (tecla_value == TECLA_CONFIRMA && contagem != '0) begin
                        if (contagem < CW'(MIN_DIGITOS)) begin
                            erro_curta_d = 1'b1;
                            clear        = 1'b1;
                        end else begin
                            estado_d      = ENVIA;
                            senha_valid_d = 1'b1;
                            senha_value_d = buffer;
                        end
                    end
                end else if (timeout_hit) begin
                    clear = 1'b1;
                end
            end
            ENVIA: begin
                clear    = 1'b1;
                estado_d = habilitar ? COLETA : OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
                clear    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q      <= OCIOSO;
            tecla_valid_q <= 1'b0;
            senha_valid_q <= 1'b0;
            erro_curta_q  <= 1'b0;
            senha_value_q <= '1;
        end else begin
            estado_q      <= estado_d;
            tecla_valid_q <= tecla_valid;
            senha_valid_q <= senha_valid_d;
            erro_curta_q  <= erro_curta_d;
            senha_value_q <= senha_value_d;
        end
    end

`ifdef SENHA_TIMEOUT_EN
    localparam int unsigned IW = $clog2(TIMEOUT_CICLOS);

    logic [IW-1:0] ocioso_q, ocioso_d;
    logic          timeout_q;

    assign timeout_hit = (estado_q == COLETA) && habilitar && !evento && (contagem != '0) &&
                         (ocioso_q == IW'(TIMEOUT_CICLOS - 1));

    always_comb begin
        ocioso_d = ocioso_q;
        if (estado_q != COLETA || contagem == '0 || evento || timeout_hit) begin
            ocioso_d = '0;
        end else if (ocioso_q != '1) begin
            ocioso_d = ocioso_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ocioso_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            ocioso_q  <= ocioso_d;
            timeout_q <= timeout_hit;
        end
    end

    assign timeout_pulse = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    assign dec_enable  = (estado_q != OCIOSO);
    assign senha_value = senha_value_q;
    assign senha_valid = senha_valid_q;
    assign erro_curta  = erro_curta_q;
    assign num_digitos = contagem;

endmodule
